// File: rtl/alt_vipitc121_pkg.sv
// -----------------------------------------------------------------------------
// alt_vipitc121_pkg
// Shared definitions for the clocked-video-output mode scheduler:
//   sched_state_e  scheduler state encoding (IDLE, PENDING, LOAD, SETTLE)
//   SETTLE_CNT_W   width of the saturating frame counter used in SETTLE
//   MAX_MODES      largest supported number of mode register banks
//   onehot_to_sel  one-hot mode vector -> binary select (index+1, 0 = none)
// Optional build macro used by the users of this package:
//   ALT_VIPITC121_ROUND_ROBIN_EN  round-robin mode pick instead of fixed priority
// -----------------------------------------------------------------------------
package alt_vipitc121_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    LOAD    = 2'd2,
    SETTLE  = 2'd3
  } sched_state_e;

  localparam int SETTLE_CNT_W = 8;
  localparam int MAX_MODES    = 15;
  localparam int SEL_W_MAX    = 4;

  // Descending scan so that an (illegal) multi-hot input still resolves to the
  // lowest set index, matching the picker's fixed priority.
  function automatic logic [SEL_W_MAX-1:0] onehot_to_sel(input logic [MAX_MODES-1:0] oh);
    logic [SEL_W_MAX-1:0] sel;
    sel = '0;
    for (int i = MAX_MODES - 1; i >= 0; i--) begin
      if (oh[i]) sel = SEL_W_MAX'(i + 1);
    end
    return sel;
  endfunction

endpackage

// File: rtl/alt_vipitc121_mode_pick.sv
// -----------------------------------------------------------------------------
// alt_vipitc121_mode_pick
// Combinational picker: selects one requested mode out of mode_req.
// Build macro ALT_VIPITC121_ROUND_ROBIN_EN:
//   undefined - fixed priority, lowest index wins; no pointer input.
//   defined   - round robin, search starts at last_ptr+1 and wraps to 0.
// Ports:
//   mode_req  in   NO_OF_MODES       level requests, bit i = mode i
//   last_ptr  in   LOG2_NO_OF_MODES  index of last loaded mode (round robin only)
//   pick_oh   out  NO_OF_MODES       one-hot pick, 0 when nothing requested
// -----------------------------------------------------------------------------
module alt_vipitc121_mode_pick #(
  parameter int NO_OF_MODES = 3
`ifdef ALT_VIPITC121_ROUND_ROBIN_EN
  ,
  parameter int LOG2_NO_OF_MODES = 2
`endif
) (
  input  logic [NO_OF_MODES-1:0]      mode_req,
`ifdef ALT_VIPITC121_ROUND_ROBIN_EN
  input  logic [LOG2_NO_OF_MODES-1:0] last_ptr,
`endif
  output logic [NO_OF_MODES-1:0]      pick_oh
);

`ifdef ALT_VIPITC121_ROUND_ROBIN_EN
  // Two passes with constant indices: first the modes above the pointer,
  // then a wrapped pass from index 0.
  always_comb begin
    logic found;
    pick_oh = '0;
    found   = 1'b0;
    for (int i = 0; i < NO_OF_MODES; i++) begin
      if (!found && mode_req[i] && (i > int'(last_ptr))) begin
        pick_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
    for (int i = 0; i < NO_OF_MODES; i++) begin
      if (!found && mode_req[i]) begin
        pick_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`else
  always_comb begin
    logic found;
    pick_oh = '0;
    found   = 1'b0;
    for (int i = 0; i < NO_OF_MODES; i++) begin
      if (!found && mode_req[i]) begin
        pick_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/alt_vipitc121_mode_scheduler.sv
// -----------------------------------------------------------------------------
// alt_vipitc121_mode_scheduler
// Sequences video-mode changes for the clocked-video-output timing generator:
// picks a requested mode, waits for a frame boundary, loads it with a req/ack
// handshake, then waits SETTLE_FRAMES frames before reporting lock.
// Build macro ALT_VIPITC121_ROUND_ROBIN_EN selects a round-robin pick whose
// pointer advances on mode_ack; otherwise fixed lowest-index priority.
// Ports:
//   clk          in   1                 system clock
//   rst_n        in   1                 async reset, active low
//   mode_req     in   NO_OF_MODES       level requests, bit i = mode i
//   sof          in   1                 start-of-frame pulse
//   mode_ack     in   1                 timing generator accepted mode_sel
//   mode_load    out  1                 load request, held until mode_ack
//   mode_sel     out  LOG2_NO_OF_MODES  index+1 of current mode, 0 = none
//   mode_onehot  out  NO_OF_MODES       one-hot copy of mode_sel
//   mode_locked  out  1                 nonzero mode stable for SETTLE_FRAMES
//   busy         out  1                 scheduler not idle
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | current mode matches the pick; lock may be reported
// PENDING | change scheduled, waiting for sof (latest pick wins)
// LOAD    | mode_load high, waiting for mode_ack
// SETTLE  | counting sof pulses before lock; requests ignored
// -----------------------------------------------------------------------------
module alt_vipitc121_mode_scheduler
  import alt_vipitc121_pkg::*;
#(
  parameter int NO_OF_MODES      = 3,
  parameter int LOG2_NO_OF_MODES = 2,
  parameter int SETTLE_FRAMES    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NO_OF_MODES-1:0]      mode_req,
  input  logic                        sof,
  input  logic                        mode_ack,
  output logic                        mode_load,
  output logic [LOG2_NO_OF_MODES-1:0] mode_sel,
  output logic [NO_OF_MODES-1:0]      mode_onehot,
  output logic                        mode_locked,
  output logic                        busy
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_TGT = SETTLE_CNT_W'(SETTLE_FRAMES);
  localparam logic [SETTLE_CNT_W-1:0] CNT_MAX    = '1;

  sched_state_e                  state_q, state_d;
  logic [NO_OF_MODES-1:0]        pending_oh_q, pending_oh_d;
  logic [NO_OF_MODES-1:0]        mode_onehot_q, mode_onehot_d;
  logic [LOG2_NO_OF_MODES-1:0]   mode_sel_q, mode_sel_d;
  logic                          mode_load_q, mode_load_d;
  logic                          mode_locked_q, mode_locked_d;
  logic [SETTLE_CNT_W-1:0]       cnt_q, cnt_d;
  logic [SETTLE_CNT_W-1:0]       cnt_inc;
  logic [NO_OF_MODES-1:0]        pick_oh;

`ifdef ALT_VIPITC121_ROUND_ROBIN_EN
  logic [LOG2_NO_OF_MODES-1:0]   last_ptr_q, last_ptr_d;

  alt_vipitc121_mode_pick #(
    .NO_OF_MODES      (NO_OF_MODES),
    .LOG2_NO_OF_MODES (LOG2_NO_OF_MODES)
  ) u_pick (
    .mode_req (mode_req),
    .last_ptr (last_ptr_q),
    .pick_oh  (pick_oh)
  );
`else
  alt_vipitc121_mode_pick #(
    .NO_OF_MODES (NO_OF_MODES)
  ) u_pick (
    .mode_req (mode_req),
    .pick_oh  (pick_oh)
  );
`endif

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + SETTLE_CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    pending_oh_d  = pending_oh_q;
    mode_onehot_d = mode_onehot_q;
    mode_sel_d    = mode_sel_q;
    mode_load_d   = mode_load_q;
    mode_locked_d = mode_locked_q;
    cnt_d         = cnt_q;
`ifdef ALT_VIPITC121_ROUND_ROBIN_EN
    last_ptr_d    = last_ptr_q;
`endif

    unique case (state_q)
      IDLE: begin
        // Also covers a dropped request: the pick falls to another mode or 0.
        if (pick_oh != mode_onehot_q) begin
          pending_oh_d  = pick_oh;
          mode_locked_d = 1'b0;
          state_d       = PENDING;
        end
      end

      PENDING: begin
        pending_oh_d = pick_oh;
        if (pick_oh == mode_onehot_q) begin
          state_d = IDLE;
        end else if (sof) begin
          // pending_oh_q always differs from the current mode here, since it
          // was only latched while the pick differed.
          mode_onehot_d = pending_oh_q;
          mode_sel_d    = LOG2_NO_OF_MODES'(onehot_to_sel(MAX_MODES'(pending_oh_q)));
          mode_load_d   = 1'b1;
          state_d       = LOAD;
        end
      end

      LOAD: begin
        if (mode_ack) begin
          mode_load_d = 1'b0;
          cnt_d       = '0;
`ifdef ALT_VIPITC121_ROUND_ROBIN_EN
          if (|mode_onehot_q) last_ptr_d = mode_sel_q - LOG2_NO_OF_MODES'(1);
`endif
          if (SETTLE_FRAMES == 0) begin
            mode_locked_d = |mode_onehot_q;
            state_d       = IDLE;
          end else begin
            state_d = SETTLE;
          end
        end
      end

      SETTLE: begin
        if (sof) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= SETTLE_TGT) begin
            // Lock is only meaningful for a real mode, never for "no mode".
            mode_locked_d = |mode_onehot_q;
            state_d       = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pending_oh_q  <= '0;
      mode_onehot_q <= '0;
      mode_sel_q    <= '0;
      mode_load_q   <= 1'b0;
      mode_locked_q <= 1'b0;
      cnt_q         <= '0;
`ifdef ALT_VIPITC121_ROUND_ROBIN_EN
      // Pointing at the top mode makes the first search start at index 0.
      last_ptr_q    <= LOG2_NO_OF_MODES'(NO_OF_MODES - 1);
`endif
    end else begin
      state_q       <= state_d;
      pending_oh_q  <= pending_oh_d;
      mode_onehot_q <= mode_onehot_d;
      mode_sel_q    <= mode_sel_d;
      mode_load_q   <= mode_load_d;
      mode_locked_q <= mode_locked_d;
      cnt_q         <= cnt_d;
`ifdef ALT_VIPITC121_ROUND_ROBIN_EN
      last_ptr_q    <= last_ptr_d;
`endif
    end
  end

  assign mode_load   = mode_load_q;
  assign mode_sel    = mode_sel_q;
  assign mode_onehot = mode_onehot_q;
  assign mode_locked = mode_locked_q;
  assign busy        = (state_q != IDLE);

endmodule
